// File: rtl/key_schedule_gen.sv
// AES key expansion for 128/192/256-bit keys: one schedule word per cycle, packed into round keys.
// Optional reverse (decryption-order) delivery through a round-key store when KEY_SCHED_REVERSE_EN is defined.
module key_schedule_gen #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic         dec,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  state_t       state_q, state_d;
  logic [31:0]  win_q [8];
  logic [31:0]  win_d [8];
  logic [31:0]  key_w [8];
  logic [5:0]   cnt_q, cnt_d;
  logic [2:0]   mod_q, mod_d;
  logic [3:0]   nk_q, nk_d, nr_q, nr_d;
  logic [7:0]   rc_q, rc_d;
  logic [95:0]  acc_q, acc_d;
  logic         busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic         rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]   rk_idx_q, rk_idx_d;

  logic [3:0]   req_nk;
  logic [31:0]  w_prev, w_old, sub_in, sub_out, w_new;
  logic [127:0] key_full;
  logic [5:0]   last_cnt;
  logic         in_key;

`ifdef KEY_SCHED_REVERSE_EN
  logic         rev_q, rev_d;
  logic [3:0]   rd_q, rd_d;
  logic         st_we;
  logic [127:0] store_q [15];
`else
  logic         unused_dec;
  assign unused_dec = dec;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    for (int unsigned j = 0; j < 8; j++) key_w[j] = key_in[255 - 32*j -: 32];
  end

  // win_q[j] holds w[i-1-j]; the key is preloaded oldest-first so w[i<Nk] falls out of win_q[Nk-1].
  always_comb begin
    req_nk   = (key_len == 2'd0) ? 4'd4 : (key_len == 2'd1) ? 4'd6 : 4'd8;
    w_prev   = win_q[0];
    w_old    = win_q[3'(nk_q - 4'd1)];
    in_key   = cnt_q < {2'b00, nk_q};
    last_cnt = {nr_q, 2'b11};
    sub_in   = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (in_key)                             w_new = w_old;
    else if (mod_q == 3'd0)                 w_new = w_old ^ sub_out ^ {rc_q, 24'h0};
    else if (nk_q == 4'd8 && mod_q == 3'd4) w_new = w_old ^ sub_out;
    else                                    w_new = w_old ^ w_prev;
    key_full = {acc_q, w_new};
  end

  always_comb begin
    state_d    = state_q;
    for (int unsigned j = 0; j < 8; j++) win_d[j] = win_q[j];
    cnt_d      = cnt_q;
    mod_d      = mod_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    rc_d       = rc_q;
    acc_d      = acc_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
`ifdef KEY_SCHED_REVERSE_EN
    rev_d      = rev_q;
    rd_d       = rd_q;
    st_we      = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        if (key_len == 2'd3 || req_nk > MAX_NK_W) begin
          err_d = 1'b1;
        end else begin
          state_d = GEN;
          nk_d    = req_nk;
          nr_d    = req_nk + 4'd6;
          cnt_d   = '0;
          mod_d   = '0;
          rc_d    = 8'h01;
          for (int unsigned j = 0; j < 8; j++)
            win_d[j] = (4'(j) < req_nk) ? key_w[3'(req_nk - 4'd1 - 4'(j))] : '0;
`ifdef KEY_SCHED_REVERSE_EN
          rev_d   = dec;
          rd_d    = req_nk + 4'd6;
`endif
        end
      end
      GEN: begin
        if (rk_valid_q && rk_ready) rk_valid_d = 1'b0;
        if (!(rk_valid_q && !rk_ready)) begin
          win_d[0] = w_new;
          for (int unsigned j = 1; j < 8; j++) win_d[j] = win_q[j-1];
          cnt_d = cnt_q + 6'd1;
          mod_d = ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
          if (!in_key && mod_q == 3'd0) rc_d = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
          acc_d = {acc_q[63:0], w_new};
          if (cnt_q[1:0] == 2'b11) begin
`ifdef KEY_SCHED_REVERSE_EN
            if (rev_q) st_we = 1'b1;
            else
`endif
            begin
              rk_valid_d = 1'b1;
              rk_data_d  = key_full;
              rk_idx_d   = cnt_q[5:2];
              rk_last_d  = (cnt_q == last_cnt);
            end
          end
          if (cnt_q == last_cnt) state_d = OUT;
        end
      end
      OUT: begin
        if (rk_valid_q && rk_ready) begin
          rk_valid_d = 1'b0;
          if (rk_last_q) begin
            rk_last_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
`ifdef KEY_SCHED_REVERSE_EN
        if (rev_q && (!rk_valid_q || (rk_ready && !rk_last_q))) begin
          rk_valid_d = 1'b1;
          rk_data_d  = store_q[rd_q];
          rk_idx_d   = rd_q;
          rk_last_d  = (rd_q == 4'd0);
          rd_d       = rd_q - 4'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int unsigned j = 0; j < 8; j++) win_q[j] <= '0;
      cnt_q      <= '0;
      mod_q      <= '0;
      nk_q       <= '0;
      nr_q       <= '0;
      rc_q       <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
`ifdef KEY_SCHED_REVERSE_EN
      rev_q      <= 1'b0;
      rd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      for (int unsigned j = 0; j < 8; j++) win_q[j] <= win_d[j];
      cnt_q      <= cnt_d;
      mod_q      <= mod_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      rc_q       <= rc_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
`ifdef KEY_SCHED_REVERSE_EN
      rev_q      <= rev_d;
      rd_q       <= rd_d;
`endif
    end
  end

`ifdef KEY_SCHED_REVERSE_EN
  always_ff @(posedge clk) begin
    if (st_we) store_q[cnt_q[5:2]] <= key_full;
  end
`endif

  assign busy     = busy_q;
  assign err      = err_q;
  assign done     = done_q;
  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen using FIPS-197 expansion vectors.
module tb_key_schedule_gen;

  logic         clk = 1'b0;
  logic         rst_n, start, start4, dec, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, err, rk_valid, rk_last, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy4, err4, rk_valid4;
  logic         unused_rk_last4, unused_done4;
  logic [127:0] unused_rk_data4;
  logic [3:0]   unused_rk_idx4;

  always #5 clk = ~clk;

  key_schedule_gen #(.MAX_NK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in), .dec(dec),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_idx(rk_idx), .rk_last(rk_last), .done(done));

  key_schedule_gen #(.MAX_NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_len(key_len), .key_in(key_in), .dec(1'b0),
    .busy(busy4), .err(err4), .rk_valid(rk_valid4), .rk_ready(1'b1), .rk_data(unused_rk_data4),
    .rk_idx(unused_rk_idx4), .rk_last(unused_rk_last4), .done(unused_done4));

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    string        name;
    logic [1:0]   len;
    logic [255:0] key;
    bit           rnd;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [127:0] got_k [16];
  logic [3:0]   got_i [16];
  logic         got_l [16];
  int           got_t [16];
  int           n_got, first_c, stall_bad, err_seen;
  logic         done_ok, done_width;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_sched(input logic [1:0] len, input logic [255:0] key, input logic dec_i, input bit rnd);
    int c;
    bit fin, pstall;
    logic [127:0] pd;
    logic [3:0] pi;
    logic pl;
    n_got = 0; first_c = -1; stall_bad = 0; err_seen = 0; done_ok = 1'b0; done_width = 1'b0;
    fin = 1'b0; pstall = 1'b0; pd = '0; pi = '0; pl = 1'b0;
    for (int k = 0; k < 16; k++) begin got_k[k] = '0; got_i[k] = '0; got_l[k] = 1'b0; got_t[k] = 0; end
    @(negedge clk); start = 1'b1; key_len = len; key_in = key; dec = dec_i; rk_ready = 1'b1;
    @(negedge clk); start = 1'b0; key_len = 2'd3; key_in = '0; dec = ~dec_i;
    c = 0;
    while (!fin && c < 400) begin
      if (rk_valid && first_c < 0) first_c = c;
      if (err) err_seen++;
      if (pstall && (rk_valid !== 1'b1 || rk_data !== pd || rk_idx !== pi || rk_last !== pl)) stall_bad++;
      if (done) begin
        fin = 1'b1;
        done_ok = (rk_valid === 1'b0 && busy === 1'b0);
      end else begin
        start = (c == 6);  // a start while busy must be ignored
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rk_valid && rk_ready && n_got < 16) begin
          got_k[n_got] = rk_data; got_i[n_got] = rk_idx; got_l[n_got] = rk_last; got_t[n_got] = c;
          n_got++;
        end
        pstall = rk_valid && !rk_ready; pd = rk_data; pi = rk_idx; pl = rk_last;
        @(negedge clk); c++;
      end
    end
    start = 1'b0; rk_ready = 1'b1;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL timeout: done not seen within 400 cycles (got %0d keys)", n_got);
    end else begin
      @(negedge clk); done_width = done;
    end
  endtask

  task automatic check_run(input string nm, input logic [1:0] len, input logic [255:0] key,
                           input bit rev, input bit rnd, input int idx, input logic [127:0] exp);
    int nr, bad, pos;
    nr = (len == 2'd0) ? 10 : (len == 2'd1) ? 12 : 14;
    chk({nm, "_count"}, 128'(n_got), 128'(nr + 1));
    chk({nm, "_latency"}, 128'(first_c), rev ? 128'(4*(nr+1)+1) : 128'(4));
    bad = 0;
    for (int k = 0; k < n_got; k++)
      if (got_i[k] !== 4'(rev ? nr - k : k) || got_l[k] !== (k == nr)) bad++;
    chk({nm, "_order_last"}, 128'(bad), 128'(0));
    chk({nm, "_stall_hold"}, 128'(stall_bad), 128'(0));
    chk({nm, "_no_err"}, 128'(err_seen), 128'(0));
    chk({nm, "_done"}, 128'(done_ok), 128'(1));
    chk({nm, "_done_1cyc"}, 128'(done_width), 128'(0));
    pos = rev ? nr : 0;
    chk({nm, "_k0"}, got_k[pos], key[255:128]);
    pos = rev ? nr - idx : idx;
    chk({nm, "_key"}, got_k[pos], exp);
    if (!rnd && !rev) chk({nm, "_period"}, 128'(got_t[nr] - got_t[0]), 128'(4*nr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv [9];
    int cnt, w;
    tv[0] = '{"a128_k1",  2'd0, K128, 1'b0, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    tv[1] = '{"a128_k10", 2'd0, K128, 1'b0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tv[2] = '{"a128_k2r", 2'd0, K128, 1'b1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    tv[3] = '{"a128_k9r", 2'd0, K128, 1'b1, 9,  128'hac7766f319fadc2128d12941575c006e};
    tv[4] = '{"a192_k1",  2'd1, K192, 1'b0, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    tv[5] = '{"a192_k12", 2'd1, K192, 1'b1, 12, 128'he98ba06f448c773c8ecc720401002202};
    tv[6] = '{"a256_k2",  2'd2, K256, 1'b0, 2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    tv[7] = '{"a256_k3r", 2'd2, K256, 1'b1, 3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a};
    tv[8] = '{"a256_k14", 2'd2, K256, 1'b1, 14, 128'hfe4890d1e6188d0b046df344706c631e};

    rst_n = 1'b1; start = 1'b0; start4 = 1'b0; dec = 1'b0; rk_ready = 1'b1;
    key_len = '0; key_in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_last", 128'(rk_last), 128'(0));
    chk("rst_data", rk_data, 128'(0));
    chk("rst_idx", 128'(rk_idx), 128'(0));
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      run_sched(tv[t].len, tv[t].key, 1'b0, tv[t].rnd);
      check_run(tv[t].name, tv[t].len, tv[t].key, 1'b0, tv[t].rnd, tv[t].idx, tv[t].exp);
    end

    // Reserved key_len: one-cycle err, stays idle.
    @(negedge clk); key_len = 2'd3; key_in = K128; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("rsv_err", 128'(err), 128'(1));
    chk("rsv_busy", 128'(busy), 128'(0));
    @(negedge clk);
    chk("rsv_err_pulse", 128'(err), 128'(0));
    cnt = 0;
    repeat (8) begin @(negedge clk); if (rk_valid || busy || err) cnt++; end
    chk("rsv_quiet", 128'(cnt), 128'(0));

    // MAX_NK=4 instance rejects AES-192, accepts AES-128.
    @(negedge clk); key_len = 2'd1; key_in = K192; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    chk("nk4_err", 128'(err4), 128'(1));
    chk("nk4_busy", 128'(busy4), 128'(0));
    cnt = 0;
    repeat (8) begin @(negedge clk); if (rk_valid4 || busy4 || err4) cnt++; end
    chk("nk4_quiet", 128'(cnt), 128'(0));
    @(negedge clk); key_len = 2'd0; key_in = K128; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    chk("nk4_accept_busy", 128'(busy4), 128'(1));
    chk("nk4_accept_err", 128'(err4), 128'(0));

    // Reset during a stalled handshake after K3.
    @(negedge clk); key_len = 2'd0; key_in = K128; rk_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!(rk_valid && rk_idx == 4'd3) && w < 100) begin @(negedge clk); w++; end
    @(negedge clk); rk_ready = 1'b0;
    while (!(rk_valid && rk_idx == 4'd4) && w < 100) begin @(negedge clk); w++; end
    chk("mid_reach_k4", 128'(w < 100), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_valid", 128'(rk_valid), 128'(0));
    chk("mid_rst_data", rk_data, 128'(0));
    chk("mid_rst_idx_last", 128'({rk_idx, rk_last, err, done}), 128'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; rk_ready = 1'b1;
    cnt = 0;
    repeat (3) begin @(negedge clk); if (rk_valid || busy || err || done) cnt++; end
    chk("rst_release_quiet", 128'(cnt), 128'(0));
    run_sched(2'd0, K128, 1'b0, 1'b0);
    chk("post_rst_count", 128'(n_got), 128'(11));
    chk("post_rst_k0", got_k[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("post_rst_k1", got_k[1], 128'ha0fafe1788542cb123a339392a6c7605);

`ifdef KEY_SCHED_REVERSE_EN
    run_sched(2'd0, K128, 1'b1, 1'b0);
    check_run("rev128", 2'd0, K128, 1'b1, 1'b0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("rev128_first", got_k[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_sched(2'd2, K256, 1'b1, 1'b1);
    check_run("rev256", 2'd2, K256, 1'b1, 1'b1, 3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
`else
    run_sched(2'd0, K128, 1'b1, 1'b0);
    check_run("dec_ignored", 2'd0, K128, 1'b0, 1'b0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
